imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//   Writer-side front end for the instruction memory. It accepts a little-endian
//   byte stream from the host link (UART/debug bridge) and assembles it into
//   32-bit words. Each word is written through the imem write port
//   (ena/wea/addra/dina) at consecutive word addresses. busy holds the core
//   while a program image loads.
// PARAMETERS
//   ADDR_W     12    imem word-address width (matches imem addra)
//   DEPTH      1024  imem depth in words; upper bound for BASE_ADDR+count
//   BASE_ADDR  0     first word address written
// PORTS
//   clk           in   1       clock
//   rst           in   1       synchronous, active-high reset
//   start         in   1       1-cycle pulse; begins a load (ignored unless IDLE/ERR)
//   s_valid       in   1       byte stream valid
//   s_ready       out  1       byte stream ready; transfer when s_valid&&s_ready
//   s_data        in   8       stream byte
//   imem_ena      out  1       imem enable
//   imem_wea      out  4       imem byte write enables
//   imem_addra    out  ADDR_W  imem word address
//   imem_dina     out  32      imem write data
//   imem_doutb    in   32      imem combinational read data (used only with verify)
//   busy          out  1       high from start until DONE/ERR; holds core in reset
//   done          out  1       1-cycle pulse on successful completion
//   err           out  1       sticky error; cleared by start or rst
//   words_loaded  out  16      words written in current/last load
// BEHAVIOUR
//   - Reset: all outputs 0 and FSM=IDLE. Partial word and count are discarded.
//     Words already written stay in imem. Reset mid-load behaves the same.
//   - Frame: 2 length bytes (count[7:0], count[15:8]), then 4*count payload
//     bytes, LSB first. Word = {b3,b2,b1,b0}.
//   - FSM: IDLE -start-> LEN_LO -byte-> LEN_HI -byte-> check, then:
//       count==0                   -> DONE
//       count > DEPTH-BASE_ADDR    -> ERR
//       else                       -> DATA
//     DATA -4th byte-> WRITE -> (VERIFY) -> DATA, or DONE when idx==count.
//     DONE -> IDLE after 1 cycle. ERR holds until start or rst.
//   - s_ready=1 only in LEN_LO, LEN_HI and DATA. One bubble cycle per word (WRITE).
//   - WRITE: imem_ena=1, imem_wea=4'hF, imem_addra=BASE_ADDR+idx, imem_dina=word,
//     for exactly 1 cycle. idx and words_loaded increment in the same cycle.
//   - Outside WRITE/VERIFY: imem_ena=0, imem_wea=0. addra/dina hold their last value.
//   - Address never wraps: the length check guarantees BASE_ADDR+idx < DEPTH.
//   - start while busy: ignored. start in ERR: clears err, then enters LEN_LO.
//   - busy=1 in every state except IDLE and ERR. done asserts in DONE only.
// CONFIGURATION
//   `IMEM_LOADER_VERIFY_EN defined:
//     - Adds a VERIFY state after WRITE: ena=1, wea=0, same addra.
//     - If imem_doutb != word: err=1 and FSM -> ERR. Two bubble cycles per word.
//   Undefined:
//     - No VERIFY state; imem_doutb is unused.
// STRUCTURE
//   - kira_loader_pkg: ldr_state_e enum
//     (IDLE, LEN_LO, LEN_HI, DATA, WRITE, VERIFY, DONE, ERR),
//     LEN_BYTES=2, WORD_BYTES=4.
//   - Sub-module byte_packer: 2-bit lane counter plus 32-bit shift.
//     Outputs word and word_valid; has a clear input.
// TESTING
//   1. start; bytes 03 00 01 02 03 04 05 06 07 08 09 0A 0B 0C
//      -> writes addr 0,1,2 = 0x04030201, 0x08070605, 0x0C0B0A09;
//         done pulse; words_loaded=3.
//   2. start; bytes 00 00 -> done 1 cycle after LEN_HI; imem_ena never high.
//   3. start; bytes 01 04 (1025 > DEPTH) -> err=1, busy=0, s_ready=0, no writes;
//      start again clears err.
//   4. Test 1 with s_valid randomly low 50% of cycles -> identical writes and order.
//   5. rst asserted after 2 payload bytes -> all outputs 0 next cycle, no write;
//      then a full 1-word load succeeds at addr 0.
//   6. VERIFY_EN, imem_doutb forced to 0xDEADBEEF -> err after first WRITE;
//      FSM in ERR; no second write.

Source files
------------

// File: rtl/kira_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   ldr_state_e : loader FSM states
//   LEN_BYTES   : length-header bytes at the start of a frame
//   WORD_BYTES  : payload bytes per imem word
package kira_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      VERIFY,
      DONE,
      ERR
   } ldr_state_e;

   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles a little-endian byte stream into 32-bit words.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         drops any partial word (start of a new frame)
//   byte_valid    a payload byte is transferred this cycle
//   byte_data     the payload byte
//   word          {b3,b2,b1,b0}, valid in the cycle the 4th byte arrives
//   word_valid    high in the cycle the 4th byte of a word is transferred
module byte_packer
   import kira_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  lane;
   logic [23:0] shift;

   // Word is combinational so the loader can register it into the imem
   // port on the same edge that takes the final byte.
   assign word       = {byte_data, shift};
   assign word_valid = byte_valid && (lane == 2'(WORD_BYTES - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         lane  <= '0;
         shift <= '0;
      end else if (byte_valid) begin
         lane  <= lane + 2'd1;
         shift <= {byte_data, shift[23:8]};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length-prefixed little-endian byte
// stream from the host link and writes it as 32-bit words into imem at
// consecutive addresses starting at BASE_ADDR.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           1-cycle pulse, begins a load from IDLE or ERR
//   s_valid/s_ready/s_data   byte stream handshake
//   imem_ena/wea/addra/dina  imem write port (registered)
//   imem_doutb      imem read data, used only for read-back checking
//   busy            high while a load is in progress
//   done            1-cycle pulse on successful completion
//   err             sticky error, cleared by start or rst
//   words_loaded    words written in the current/last load
// Build option: define IMEM_LOADER_VERIFY_EN to read back every word after
// writing it and flag a mismatch as an error.
//
// state  | meaning
// IDLE   | waiting for start
// LEN_LO | taking count[7:0]
// LEN_HI | taking count[15:8], then range check
// DATA   | taking payload bytes
// WRITE  | one-cycle imem write of the assembled word
// VERIFY | one-cycle read-back compare (verify build only)
// DONE   | one-cycle completion pulse
// ERR    | bad length or read-back mismatch; waits for start
module imem_loader
   import kira_loader_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int DEPTH     = 1024,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   output logic              imem_ena,
   output logic [3:0]        imem_wea,
   output logic [ADDR_W-1:0] imem_addra,
   output logic [31:0]       imem_dina,
   input  logic [31:0]       imem_doutb,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       words_loaded
);

   localparam int unsigned MAX_WORDS = DEPTH - BASE_ADDR;

   ldr_state_e  state;
   logic [15:0] count;
   logic [15:0] len_full;
   logic [31:0] word;
   logic        word_valid;
   logic        pack_clear;
   logic        pack_valid;

   assign len_full   = {s_data, count[7:0]};
   assign pack_clear = start && (state == IDLE || state == ERR);
   // s_ready is always high in DATA, so a valid byte here is a transfer.
   assign pack_valid = (state == DATA) && s_valid;

`ifndef IMEM_LOADER_VERIFY_EN
   logic unused_doutb;
   assign unused_doutb = ^imem_doutb;
`endif

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (pack_clear),
      .byte_valid (pack_valid),
      .byte_data  (s_data),
      .word       (word),
      .word_valid (word_valid)
   );

   // Outputs are registered: each transition also loads the output values
   // that belong to the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         count        <= '0;
         s_ready      <= 1'b0;
         imem_ena     <= 1'b0;
         imem_wea     <= '0;
         imem_addra   <= '0;
         imem_dina    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
      end else begin
         done     <= 1'b0;
         imem_ena <= 1'b0;
         imem_wea <= '0;
         case (state)
            IDLE, ERR: begin
               if (start) begin
                  state        <= LEN_LO;
                  s_ready      <= 1'b1;
                  busy         <= 1'b1;
                  err          <= 1'b0;
                  count        <= '0;
                  words_loaded <= '0;
               end
            end
            LEN_LO: begin
               if (s_valid) begin
                  count[7:0] <= s_data;
                  state      <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (s_valid) begin
                  count <= len_full;
                  if (len_full == 16'd0) begin
                     state   <= DONE;
                     s_ready <= 1'b0;
                     done    <= 1'b1;
                  end else if (32'(len_full) > MAX_WORDS) begin
                     state   <= ERR;
                     s_ready <= 1'b0;
                     busy    <= 1'b0;
                     err     <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (word_valid) begin
                  state        <= WRITE;
                  s_ready      <= 1'b0;
                  imem_ena     <= 1'b1;
                  imem_wea     <= 4'hF;
                  imem_addra   <= ADDR_W'(BASE_ADDR + int'(words_loaded));
                  imem_dina    <= word;
                  words_loaded <= words_loaded + 16'd1;
               end
            end
            WRITE: begin
`ifdef IMEM_LOADER_VERIFY_EN
               state    <= VERIFY;
               imem_ena <= 1'b1;
`else
               if (words_loaded == count) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state   <= DATA;
                  s_ready <= 1'b1;
               end
`endif
            end
`ifdef IMEM_LOADER_VERIFY_EN
            VERIFY: begin
               // imem_dina still holds the word just written.
               if (imem_doutb != imem_dina) begin
                  state <= ERR;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end else if (words_loaded == count) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state   <= DATA;
                  s_ready <= 1'b1;
               end
            end
`endif
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               s_ready <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
